// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared limits, segment field layout and sizing helper for the data-mux TDR.
package firebird7_in_gate1_tessent_data_mux_pkg;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;
    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 32;

    localparam int SEL_BIT  = 0;
    localparam int DATA_LSB = 1;

    function automatic int seg_len(input int width);
        return width + 1;
    endfunction
endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr_chan.sv
// One channel: update-stage segment register and functional/override output mux.
module firebird7_in_gate1_tessent_data_mux_tdr_chan
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    upd_en_i,
    input  logic [WIDTH:0]          seg_i,
    input  logic [WIDTH-1:0]        func_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    sel_o
);
    localparam int SEG = seg_len(WIDTH);

    logic [SEG-1:0] upd_q;
    logic [SEG-1:0] upd_d;

    always_comb begin
        upd_d = upd_q;
        if (upd_en_i) upd_d = seg_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) upd_q <= '0;
        else       upd_q <= upd_d;
    end

    assign sel_o  = upd_q[SEL_BIT];
    assign data_o = sel_o ? upd_q[DATA_LSB +: WIDTH] : func_i;
endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// IJTAG data-mux TDR: capture/shift register in the top, per-channel update stage and mux below.
module firebird7_in_gate1_tessent_data_mux_tdr
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 3
) (
    input  logic                      ijtag_tck,
    input  logic                      ijtag_reset,
    input  logic                      ijtag_sel,
    input  logic                      ijtag_ce,
    input  logic                      ijtag_se,
    input  logic                      ijtag_ue,
    input  logic                      ijtag_si,
    output logic                      ijtag_so,
    input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic                      ijtag_active
);
    localparam int SEG = seg_len(WIDTH);
    localparam int LEN = CHANNELS * SEG;

    logic [LEN-1:0]      sr_q;
    logic [LEN-1:0]      sr_d;
    logic [LEN-1:0]      cap_v;
    logic [CHANNELS-1:0] upd_sel;

    logic capture_en;
    logic shift_en;
    logic update_en;

    assign capture_en = ijtag_sel && ijtag_ce;
    assign shift_en   = ijtag_sel && ijtag_se && !ijtag_ce;
    // ue with se is ignored so a shift never leaks half-loaded data into the outputs.
    assign update_en  = ijtag_sel && ijtag_ue && !ijtag_se;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign cap_v[c*SEG + SEL_BIT]            = upd_sel[c];
        assign cap_v[c*SEG + DATA_LSB +: WIDTH]  = functional_data_in[c*WIDTH +: WIDTH];

        firebird7_in_gate1_tessent_data_mux_tdr_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i    (ijtag_tck),
            .rst_i    (ijtag_reset),
            .upd_en_i (update_en),
            .seg_i    (sr_q[c*SEG +: SEG]),
            .func_i   (functional_data_in[c*WIDTH +: WIDTH]),
            .data_o   (data_out[c*WIDTH +: WIDTH]),
            .sel_o    (upd_sel[c])
        );
    end

    always_comb begin
        sr_d = sr_q;
        if (capture_en)    sr_d = cap_v;
        else if (shift_en) sr_d = {ijtag_si, sr_q[LEN-1:1]};
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) sr_q <= '0;
        else             sr_q <= sr_d;
    end

    assign ijtag_so     = sr_q[0];
    assign ijtag_active = |upd_sel;
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Scoreboard bench: queue-based TDR model feeds expectations, negedge monitor compares.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;
    localparam int CH  = 2;
    localparam int W   = 3;
    localparam int SEG = W + 1;
    localparam int LEN = CH * SEG;
    localparam int DW  = CH * W;

    logic          tck = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
    logic [DW-1:0] fdi = 6'b101_010;
    logic [DW-1:0] dout;
    logic          so;
    logic          active;

    int n_cmp = 0;
    int n_bad = 0;

    firebird7_in_gate1_tessent_data_mux_tdr #(.CHANNELS(CH), .WIDTH(W)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .data_out           (dout),
        .ijtag_active       (active)
    );

    initial forever #5 tck = ~tck;

    // Model: scan chain as a bit queue (front = scan-out end), update stage per channel.
    bit       m_sr[$];
    bit       m_sel[CH];
    bit [W-1:0] m_ovr[CH];

    typedef struct {
        logic [DW-1:0] dout;
        logic          so;
        logic          active;
        string         tag;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_dout(input logic [DW-1:0] f);
        logic [DW-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c*W +: W] = m_sel[c] ? m_ovr[c] : f[c*W +: W];
        return r;
    endfunction

    function automatic bit exp_active();
        bit a = 0;
        for (int c = 0; c < CH; c++) a |= m_sel[c];
        return a;
    endfunction

    function automatic void model_reset();
        m_sr.delete();
        for (int k = 0; k < LEN; k++) m_sr.push_back(1'b0);
        for (int c = 0; c < CH; c++) begin m_sel[c] = 0; m_ovr[c] = '0; end
    endfunction

    function automatic void model_edge(input bit s, input bit c_e, input bit s_e,
                                       input bit u_e, input bit i, input logic [DW-1:0] f);
        bit old[$];
        bit nq[$];
        old = m_sr;
        if (s && c_e) begin
            for (int c = 0; c < CH; c++) begin
                nq.push_back(m_sel[c]);
                for (int b = 0; b < W; b++) nq.push_back(f[c*W + b]);
            end
            m_sr = nq;
        end else if (s && s_e) begin
            void'(m_sr.pop_front());
            m_sr.push_back(i);
        end
        if (s && u_e && !s_e) begin
            for (int c = 0; c < CH; c++) begin
                m_sel[c] = old[c*SEG];
                for (int b = 0; b < W; b++) m_ovr[c][b] = old[c*SEG + 1 + b];
            end
        end
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.dout   = exp_dout(fdi);
        e.so     = m_sr[0];
        e.active = exp_active();
        e.tag    = tag;
        sb.push_back(e);
    endfunction

    // Monitor: checks happen at negedge, before the stimulus moves inputs at negedge+1.
    initial begin
        exp_t e;
        forever begin
            @(negedge tck);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".dout"},   32'(dout),   32'(e.dout));
                chk({e.tag, ".so"},     32'(so),     32'(e.so));
                chk({e.tag, ".active"}, 32'(active), 32'(e.active));
            end
        end
    end

    task automatic cyc(input bit s, input bit c_e, input bit s_e, input bit u_e,
                       input bit i, input logic [DW-1:0] f, input string tag);
        @(negedge tck);
        #1;
        rst = 1'b0; sel = s; ce = c_e; se = s_e; ue = u_e; si = i; fdi = f;
        @(posedge tck);
        model_edge(s, c_e, s_e, u_e, i, f);
        push_exp(tag);
        #1;
    endtask

    task automatic shift8(input logic [LEN-1:0] v, input logic [DW-1:0] f);
        for (int k = 0; k < LEN; k++) cyc(1, 0, 1, 0, v[k], f, "shift");
    endtask

    task automatic reset_pulse(input logic [DW-1:0] f, input string tag);
        @(negedge tck);
        #1;
        rst = 1'b1; fdi = f;
        #1;
        chk({tag, ".async_dout"},   32'(dout),   32'(f));
        chk({tag, ".async_active"}, 32'(active), 32'd0);
        chk({tag, ".async_so"},     32'(so),     32'd0);
        model_reset();
        @(posedge tck);
        push_exp({tag, ".held"});
        #1;
    endtask

    logic [LEN-1:0] so_seq;

    initial begin
        model_reset();
        #2;
        chk("rst.dout",   32'(dout),   32'(6'b101_010));
        chk("rst.so",     32'(so),     32'd0);
        chk("rst.active", 32'(active), 32'd0);
        @(posedge tck); push_exp("rst.edge"); #1;

        // Load channel1 data with select off: outputs must not move.
        shift8(8'b1110_0000, 6'b101_010);
        cyc(1, 0, 0, 1, 0, 6'b101_010, "upd1");
        chk("upd1.dout",   32'(dout),   32'(6'b101_010));
        chk("upd1.active", 32'(active), 32'd0);

        shift8(8'b0000_1111, 6'b101_010);
        cyc(1, 0, 0, 1, 0, 6'b101_010, "upd2");
        chk("upd2.dout",   32'(dout),   32'(6'b101_111));
        chk("upd2.active", 32'(active), 32'd1);

        // Capture with channel0 overridden, then stream the chain out.
        cyc(1, 1, 0, 0, 0, 6'b011_100, "cap");
        so_seq[0] = so;
        for (int k = 1; k < LEN; k++) begin
            cyc(1, 0, 1, 0, 0, 6'b011_100, "capsh");
            so_seq[k] = so;
        end
        cyc(1, 0, 1, 0, 0, 6'b011_100, "capsh");
        chk("cap.so_seq", 32'(so_seq), 32'(8'b0110_1001));

        // ue with se, and everything with sel low: no update.
        cyc(1, 0, 1, 1, 1, 6'b011_100, "ue_se");
        chk("ue_se.dout", 32'(dout), 32'(6'b011_111));
        cyc(0, 1, 1, 1, 0, 6'b011_100, "nosel");
        chk("nosel.dout",   32'(dout),   32'(6'b011_111));
        chk("nosel.active", 32'(active), 32'd1);

        // Reset mid-shift with override active, then a full reload.
        for (int k = 0; k < 4; k++) cyc(1, 0, 1, 0, 1, 6'b011_100, "preRst");
        reset_pulse(6'b011_100, "midrst");
        shift8(8'b0000_1111, 6'b011_100);
        cyc(1, 0, 0, 1, 0, 6'b011_100, "reload");
        chk("reload.dout",   32'(dout),   32'(6'b011_111));
        chk("reload.active", 32'(active), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0)
                reset_pulse(DW'($urandom), "rnd_rst");
            else
                cyc(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 5) == 0),
                    bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 1)), DW'($urandom), "rnd");
        end

        repeat (3) @(negedge tck);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
